// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared encodings for the intersection controller and anything that decodes
// its status outputs: phase codes, approach indices, lamp patterns, and the
// lamp decode used for every approach.
// -----------------------------------------------------------------------------
package traffic_pkg;

    // Phase codes double as the value driven on the 2-bit `phase` output.
    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_HOLD   = 2'd3
    } phase_t;

    // Approach indices; N->E->S->W is also the service order, so "next
    // approach" is a plain 2-bit increment that wraps W->N.
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Lamp patterns, {red,yellow,green}, always one-hot.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Lamp pattern for `approach` when the controller is in phase `ph`
    // serving approach `dir`. Only the served approach can leave red, which
    // is what keeps at most one approach non-red at any time.
    function automatic logic [2:0] lamp_for(input phase_t     ph,
                                            input logic [1:0] dir,
                                            input logic [1:0] approach);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        if (approach == dir) begin
            if (ph == PH_GREEN)
                lamp = LAMP_GRN;
            else if (ph == PH_YELLOW)
                lamp = LAMP_YEL;
        end
        return lamp;
    endfunction

endpackage : traffic_pkg

// File: rtl/tick_edge_det.sv
// -----------------------------------------------------------------------------
// tick_edge_det
// Turns a slow, same-domain square wave into a one-clk-cycle pulse on each of
// its rising edges. The history register resets to 1 so that a level that is
// already high when reset is released is not mistaken for a fresh edge.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   level  in   square wave, already registered in the clk domain
//   pulse  out  one-cycle pulse, high in the cycle where level rose
// -----------------------------------------------------------------------------
module tick_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst)
            level_q <= 1'b1;
        else
            level_q <= level;
    end

    // The source is already in the clk domain, so no synchronizer is needed.
    assign pulse = level & ~level_q;

endmodule : tick_edge_det

// File: rtl/traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm
// Four-way intersection controller. Serves N->E->S->W in turn; each approach
// gets GREEN, then YELLOW, then an all-red clearance. Timing is counted in
// seconds ticks derived from the divider's 1 Hz square wave, which is only
// ever sampled as data in the clk domain.
//
// Optional feature (macro TRAFFIC_EMERGENCY_EN): `emerg` cuts a green short
// to yellow, and after the clearance parks the intersection in HOLD (all red)
// until `emerg` drops; then a fresh clearance runs and service resumes with
// the next approach. Without the macro `emerg` is ignored and HOLD is
// unreachable.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst          in   synchronous active-high reset
//   divided_clk  in   1 Hz square wave from the divider (clk domain)
//   emerg        in   emergency preempt request
//   light_n/e/s/w out {red,yellow,green} lamps per approach, registered
//   active_dir   out  approach being served, 0=N 1=E 2=S 3=W
//   phase        out  0=GREEN 1=YELLOW 2=ALLRED 3=HOLD
//   sec_left     out  ticks remaining in the current phase minus one
// -----------------------------------------------------------------------------
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_SEC  = 10,  // 1..255
    parameter int YELLOW_SEC = 3,   // 1..255
    parameter int ALLRED_SEC = 2    // 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       divided_clk,
    input  logic       emerg,
    output logic [2:0] light_n,
    output logic [2:0] light_e,
    output logic [2:0] light_s,
    output logic [2:0] light_w,
    output logic [1:0] active_dir,
    output logic [1:0] phase,
    output logic [7:0] sec_left
);

    // sec_left holds "remaining minus one", so each phase loads duration-1.
    localparam logic [7:0] GREEN_LOAD  = 8'(GREEN_SEC  - 1);
    localparam logic [7:0] YELLOW_LOAD = 8'(YELLOW_SEC - 1);
    localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_SEC - 1);

    logic       tick;
    logic       expire;    // tick arriving on the last second of a phase
    logic       count;     // tick arriving with seconds still left

    phase_t     ph_q, ph_d;
    logic [1:0] dir_q, dir_d;
    logic [7:0] sec_q, sec_d;

    tick_edge_det u_tick (
        .clk   (clk),
        .rst   (rst),
        .level (divided_clk),
        .pulse (tick)
    );

    assign expire = tick && (sec_q == 8'd0);
    assign count  = tick && (sec_q != 8'd0);

`ifndef TRAFFIC_EMERGENCY_EN
    // Preemption is compiled out; the input is intentionally left unused.
    logic unused_emerg;
    assign unused_emerg = emerg;
`endif

    // Next-state decode. The registered lamps are derived from this same
    // next state, so lamps and status change on the same edge.
    // NOTE: every always_comb output is given a default before the case so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        ph_d  = ph_q;
        dir_d = dir_q;
        sec_d = sec_q;

        case (ph_q)
            PH_GREEN: begin
                if (expire) begin
                    ph_d  = PH_YELLOW;
                    sec_d = YELLOW_LOAD;
                end else if (count) begin
                    sec_d = sec_q - 8'd1;
                end
`ifdef TRAFFIC_EMERGENCY_EN
                // Preemption ends green on the very next edge, tick or not.
                if (emerg) begin
                    ph_d  = PH_YELLOW;
                    sec_d = YELLOW_LOAD;
                end
`endif
            end

            // Yellow always runs its full time, preemption or not.
            PH_YELLOW: begin
                if (expire) begin
                    ph_d  = PH_ALLRED;
                    sec_d = ALLRED_LOAD;
                end else if (count) begin
                    sec_d = sec_q - 8'd1;
                end
            end

            PH_ALLRED: begin
                if (expire) begin
                    ph_d  = PH_GREEN;
                    dir_d = dir_q + 2'd1;   // wraps W->N
                    sec_d = GREEN_LOAD;
`ifdef TRAFFIC_EMERGENCY_EN
                    // Stay with the same approach so the resume picks the next one.
                    if (emerg) begin
                        ph_d  = PH_HOLD;
                        dir_d = dir_q;
                        sec_d = 8'd0;
                    end
`endif
                end else if (count) begin
                    sec_d = sec_q - 8'd1;
                end
            end

            default: begin  // PH_HOLD
`ifdef TRAFFIC_EMERGENCY_EN
                if (emerg) begin
                    sec_d = 8'd0;
                end else begin
                    ph_d  = PH_ALLRED;
                    sec_d = ALLRED_LOAD;
                end
`else
                // Unreachable in this build; fall back to a safe clearance.
                ph_d  = PH_ALLRED;
                sec_d = ALLRED_LOAD;
`endif
            end
        endcase
    end

    // Reset parks the controller at the start of W's clearance, so the first
    // green goes to N after ALLRED_SEC ticks. Reset dominates a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= PH_ALLRED;
            dir_q   <= DIR_W;
            sec_q   <= ALLRED_LOAD;
            light_n <= LAMP_RED;
            light_e <= LAMP_RED;
            light_s <= LAMP_RED;
            light_w <= LAMP_RED;
        end else begin
            ph_q    <= ph_d;
            dir_q   <= dir_d;
            sec_q   <= sec_d;
            light_n <= lamp_for(ph_d, dir_d, DIR_N);
            light_e <= lamp_for(ph_d, dir_d, DIR_E);
            light_s <= lamp_for(ph_d, dir_d, DIR_S);
            light_w <= lamp_for(ph_d, dir_d, DIR_W);
        end
    end

    assign active_dir = dir_q;
    assign phase      = ph_q;
    assign sec_left   = sec_q;

endmodule : traffic_light_fsm

// File: tb/tb_traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_fsm
// Bench for traffic_light_fsm with GREEN=3, YELLOW=1, ALLRED=1 and a
// divided_clk of 8 cycles high / 8 cycles low. A timeline model (seconds
// elapsed since the start of N green) gives the expected outputs on every
// cycle; directed literal checks pin the key points of the sequence.
// -----------------------------------------------------------------------------
module tb_traffic_light_fsm;

    localparam int G  = 3;
    localparam int Y  = 1;
    localparam int A  = 1;
    localparam int L  = G + Y + A;        // seconds per approach
    localparam int T0 = 4 * L - A;        // reset = start of W's clearance

    logic       clk = 1'b0;
    logic       rst;
    logic       divided_clk;
    logic       emerg;
    logic [2:0] light_n, light_e, light_s, light_w;
    logic [1:0] active_dir;
    logic [1:0] phase;
    logic [7:0] sec_left;

    int total = 0;
    int bad   = 0;

    traffic_light_fsm #(
        .GREEN_SEC  (G),
        .YELLOW_SEC (Y),
        .ALLRED_SEC (A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .divided_clk (divided_clk),
        .emerg       (emerg),
        .light_n     (light_n),
        .light_e     (light_e),
        .light_s     (light_s),
        .light_w     (light_w),
        .active_dir  (active_dir),
        .phase       (phase),
        .sec_left    (sec_left)
    );

    always #10 clk = ~clk;   // 50 MHz

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic [1:0]  ph;
        logic [1:0]  dir;
        logic [7:0]  sec;
        logic [11:0] lamps;   // {n,e,s,w}
    } obs_t;

    int   t_model;
    logic prev_level;
    logic model_en = 1'b0;

    // Seconds since reset advance on each rising edge of divided_clk seen
    // while out of reset; reset returns the timeline to W's clearance.
    always @(posedge clk) begin
        if (rst) begin
            t_model    <= T0;
            prev_level <= 1'b1;
        end else begin
            if (divided_clk && !prev_level)
                t_model <= t_model + 1;
            prev_level <= divided_clk;
        end
    end

    function automatic obs_t expect_at(input int t);
        obs_t o;
        int u, d, r;
        u = t % (4 * L);
        d = u / L;
        r = u % L;
        if (r < G) begin
            o.ph = 2'd0; o.sec = 8'(G - 1 - r);
        end else if (r < G + Y) begin
            o.ph = 2'd1; o.sec = 8'(G + Y - 1 - r);
        end else begin
            o.ph = 2'd2; o.sec = 8'(L - 1 - r);
        end
        o.dir = 2'(d);
        for (int a = 0; a < 4; a++) begin
            logic [2:0] lamp;
            lamp = 3'b100;
            if (a == d && o.ph == 2'd0) lamp = 3'b001;
            if (a == d && o.ph == 2'd1) lamp = 3'b010;
            o.lamps[(3 - a) * 3 +: 3] = lamp;
        end
        return o;
    endfunction

    function automatic logic lamps_ok(input logic [11:0] lamps);
        int nonred;
        logic ok;
        nonred = 0;
        ok     = 1'b1;
        for (int a = 0; a < 4; a++) begin
            logic [2:0] l;
            l = lamps[a * 3 +: 3];
            if (l != 3'b100 && l != 3'b010 && l != 3'b001) ok = 1'b0;
            if (l != 3'b100) nonred++;
        end
        return ok && (nonred <= 1);
    endfunction

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_en) begin
            obs_t act;
            act = '{ph: phase, dir: active_dir, sec: sec_left,
                    lamps: {light_n, light_e, light_s, light_w}};
            check("model", 32'(act), 32'(expect_at(t_model)));
            check("lamp_invariant", 32'(lamps_ok(act.lamps)), 32'd1);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called on a falling edge with divided_clk low; returns one falling edge
    // later, i.e. just after the tick edge, with divided_clk still high.
    task automatic rise();
        divided_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic fall_rest();
        repeat (7) @(negedge clk);
        divided_clk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic drive_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            rise();
            fall_rest();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst         = 1'b1;
        divided_clk = 1'b1;
        emerg       = 1'b0;
        repeat (3) @(negedge clk);
        model_en = 1'b1;
        rst      = 1'b0;

        // Released with divided_clk already high: no tick, still all red.
        repeat (3) @(negedge clk);
        check("reset_phase", 32'(phase), 32'd2);
        check("reset_dir",   32'(active_dir), 32'd3);
        check("reset_sec",   32'(sec_left), 32'd0);
        check("reset_lamps", 32'({light_n, light_e, light_s, light_w}), 32'h924);

        divided_clk = 1'b0;
        repeat (8) @(negedge clk);

        // Tick 1: N green.
        rise();
        check("t1_light_n", 32'(light_n), 32'b001);
        check("t1_others",  32'({light_e, light_s, light_w}), 32'({3'b100, 3'b100, 3'b100}));
        check("t1_dir",     32'(active_dir), 32'd0);
        check("t1_sec",     32'(sec_left), 32'd2);
        fall_rest();

        // Ticks 2..20 end in W's clearance; tick 21 wraps to N green.
        drive_ticks(19);
        check("t20_phase", 32'(phase), 32'd2);
        check("t20_dir",   32'(active_dir), 32'd3);
        rise();
        check("t21_phase",   32'(phase), 32'd0);
        check("t21_dir",     32'(active_dir), 32'd0);
        check("t21_light_n", 32'(light_n), 32'b001);
        check("t21_light_w", 32'(light_w), 32'b100);
        fall_rest();

        // Long soak, then land in E yellow (tick 209).
        drive_ticks(187);
        rise();
        check("eyel_phase",   32'(phase), 32'd1);
        check("eyel_dir",     32'(active_dir), 32'd1);
        check("eyel_light_e", 32'(light_e), 32'b010);
        fall_rest();

        // Reset coincident with the tick that would end E yellow.
        rst         = 1'b1;
        divided_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_phase", 32'(phase), 32'd2);
        check("rst_mid_dir",   32'(active_dir), 32'd3);
        check("rst_mid_sec",   32'(sec_left), 32'd0);
        check("rst_mid_lamps", 32'({light_n, light_e, light_s, light_w}), 32'h924);
        fall_rest();

        // divided_clk held high for 100 cycles gives one decrement only.
        rise();
        check("hold_pre_sec", 32'(sec_left), 32'd2);
        fall_rest();
        divided_clk = 1'b1;
        @(negedge clk);
        check("hold_first_sec", 32'(sec_left), 32'd1);
        repeat (99) @(negedge clk);
        check("hold_last_sec",   32'(sec_left), 32'd1);
        check("hold_last_phase", 32'(phase), 32'd0);
        divided_clk = 1'b0;
        repeat (8) @(negedge clk);

`ifdef TRAFFIC_EMERGENCY_EN
        // Fresh start: N green with sec_left=2, then preempt.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rise();
        check("em_start_sec", 32'(sec_left), 32'd2);
        fall_rest();
        model_en = 1'b0;
        emerg    = 1'b1;
        @(negedge clk);
        check("em_yellow_n",   32'(light_n), 32'b010);
        check("em_yellow_ph",  32'(phase), 32'd1);
        check("em_yellow_sec", 32'(sec_left), 32'd0);
        rise();
        check("em_allred_ph",  32'(phase), 32'd2);
        check("em_allred_dir", 32'(active_dir), 32'd0);
        fall_rest();
        rise();
        check("em_hold_ph",    32'(phase), 32'd3);
        check("em_hold_lamps", 32'({light_n, light_e, light_s, light_w}), 32'h924);
        fall_rest();
        drive_ticks(5);
        check("em_hold_stay", 32'(phase), 32'd3);
        check("em_hold_sec",  32'(sec_left), 32'd0);
        emerg = 1'b0;
        @(negedge clk);
        check("em_resume_ph",  32'(phase), 32'd2);
        check("em_resume_dir", 32'(active_dir), 32'd0);
        check("em_resume_sec", 32'(sec_left), 32'd0);
        rise();
        check("em_next_light_e", 32'(light_e), 32'b001);
        check("em_next_dir",     32'(active_dir), 32'd1);
        check("em_next_sec",     32'(sec_left), 32'd2);
        fall_rest();
`endif

        model_en = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_traffic_light_fsm
